// File: rtl/dfdd_pkg.sv
// Shared FP16 field constants, types and the flush-to-zero sanitiser for the DFDD front-end.
package dfdd_pkg;

    localparam int unsigned EXP_WIDTH_DEF  = 5;
    localparam int unsigned FRAC_WIDTH_DEF = 10;
    localparam int unsigned FP16_WIDTH     = 1 + EXP_WIDTH_DEF + FRAC_WIDTH_DEF;
    localparam int unsigned FRAC_MSB       = FRAC_WIDTH_DEF - 1;
    localparam int unsigned EXP_LSB        = FRAC_WIDTH_DEF;
    localparam int unsigned EXP_MSB        = EXP_LSB + EXP_WIDTH_DEF - 1;
    localparam int unsigned COORD_WIDTH    = 16;

    typedef logic [FP16_WIDTH-1:0]  fp16_t;
    typedef logic [COORD_WIDTH-1:0] coord_t;

    // Zero exponent (subnormal or signed zero) and all-ones exponent (NaN/Inf) both map to +0.
    function automatic fp16_t ftz_sanitize(input fp16_t x);
        logic [EXP_WIDTH_DEF-1:0] exp_f;
        fp16_t                    res;
        exp_f = x[EXP_MSB:EXP_LSB];
        res   = x;
        if ((exp_f == '0) || (exp_f == '1)) begin
            res = '0;
        end
        return res;
    endfunction

endpackage

// File: rtl/dfdd_sync_fifo.sv
// Single-clock FIFO with registered count/full/empty flags and a combinational head read.
module dfdd_sync_fifo #(
    parameter  int unsigned DATA_WIDTH = 16,
    parameter  int unsigned DEPTH      = 16,
    localparam int unsigned AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW         = AW + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_c_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [CW-1:0]         count_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  push_ok, pop_ok;

    assign push_ok = push_i & ~full_q;
    assign pop_ok  = pop_i & ~empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage carries no reset; entries are only read once written.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign head_c_o = mem_q[rd_ptr_q];
    assign full_o   = full_q;
    assign empty_o  = empty_q;
    assign count_o  = count_q;

endmodule

// File: rtl/dual_stream_aligner.sv
// Buffers the I_A and I_T streams, pops them in lockstep and tags each pair with raster col/row.
// Define DFDD_ALIGNER_FTZ_EN to flush subnormals, NaN/Inf and negative zero to +0 on the pop path.
module dual_stream_aligner
    import dfdd_pkg::*;
#(
    parameter  int unsigned IMAGE_WIDTH  = 640,
    parameter  int unsigned IMAGE_HEIGHT = 480,
    parameter  int unsigned FIFO_DEPTH   = 16,
    parameter  int unsigned EXP_WIDTH    = EXP_WIDTH_DEF,
    parameter  int unsigned FRAC_WIDTH   = FRAC_WIDTH_DEF,
    localparam int unsigned FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [FP_WIDTH_REG-1:0] a_data_i,
    input  logic                    a_valid_i,
    output logic                    a_ready_o,
    input  logic [FP_WIDTH_REG-1:0] t_data_i,
    input  logic                    t_valid_i,
    output logic                    t_ready_o,
    output logic [FP_WIDTH_REG-1:0] i_a_o,
    output logic [FP_WIDTH_REG-1:0] i_t_o,
    output logic [15:0]             col_o,
    output logic [15:0]             row_o,
    output logic                    valid_o,
    output logic                    frame_done_o,
    output logic                    overflow_o
);

    localparam int unsigned CW       = ((FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1) + 1;
    localparam coord_t      LAST_COL = coord_t'(IMAGE_WIDTH - 1);
    localparam coord_t      LAST_ROW = coord_t'(IMAGE_HEIGHT - 1);

    logic [FP_WIDTH_REG-1:0] a_head, t_head;
    logic                    a_full, t_full, a_empty, t_empty;
    logic [CW-1:0]           a_count, t_count;
    logic                    a_push, t_push, pop;
    logic                    unused_cnt_c;

    logic [FP_WIDTH_REG-1:0] i_a_q, i_a_d, i_t_q, i_t_d;
    coord_t                  col_q, col_d, row_q, row_d;
    coord_t                  col_out_q, col_out_d, row_out_q, row_out_d;
    logic                    valid_q, valid_d;
    logic                    frame_done_q, frame_done_d;
    logic                    overflow_q, overflow_d;

    assign a_ready_o    = ~a_full;
    assign t_ready_o    = ~t_full;
    assign a_push       = a_valid_i & ~a_full;
    assign t_push       = t_valid_i & ~t_full;
    assign pop          = ~a_empty & ~t_empty;
    assign unused_cnt_c = ^{a_count, t_count};

    dfdd_sync_fifo #(.DATA_WIDTH(FP_WIDTH_REG), .DEPTH(FIFO_DEPTH)) u_a_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push_i   (a_push),
        .data_i   (a_data_i),
        .pop_i    (pop),
        .head_c_o (a_head),
        .full_o   (a_full),
        .empty_o  (a_empty),
        .count_o  (a_count)
    );

    dfdd_sync_fifo #(.DATA_WIDTH(FP_WIDTH_REG), .DEPTH(FIFO_DEPTH)) u_t_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push_i   (t_push),
        .data_i   (t_data_i),
        .pop_i    (pop),
        .head_c_o (t_head),
        .full_o   (t_full),
        .empty_o  (t_empty),
        .count_o  (t_count)
    );

    // Pop path: load the pair and the pre-increment coordinates, then advance the raster.
    always_comb begin
        i_a_d        = i_a_q;
        i_t_d        = i_t_q;
        col_d        = col_q;
        row_d        = row_q;
        col_out_d    = col_out_q;
        row_out_d    = row_out_q;
        valid_d      = 1'b0;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q | (a_valid_i & a_full) | (t_valid_i & t_full);
        if (pop) begin
`ifdef DFDD_ALIGNER_FTZ_EN
            i_a_d = FP_WIDTH_REG'(ftz_sanitize(fp16_t'(a_head)));
            i_t_d = FP_WIDTH_REG'(ftz_sanitize(fp16_t'(t_head)));
`else
            i_a_d = a_head;
            i_t_d = t_head;
`endif
            valid_d   = 1'b1;
            col_out_d = col_q;
            row_out_d = row_q;
            if (col_q == LAST_COL) begin
                col_d = '0;
                if (row_q == LAST_ROW) begin
                    row_d        = '0;
                    frame_done_d = 1'b1;
                end else begin
                    row_d = row_q + coord_t'(1);
                end
            end else begin
                col_d = col_q + coord_t'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            i_a_q        <= '0;
            i_t_q        <= '0;
            col_q        <= '0;
            row_q        <= '0;
            col_out_q    <= '0;
            row_out_q    <= '0;
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            i_a_q        <= i_a_d;
            i_t_q        <= i_t_d;
            col_q        <= col_d;
            row_q        <= row_d;
            col_out_q    <= col_out_d;
            row_out_q    <= row_out_d;
            valid_q      <= valid_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    assign i_a_o        = i_a_q;
    assign i_t_o        = i_t_q;
    assign col_o        = col_out_q;
    assign row_o        = row_out_q;
    assign valid_o      = valid_q;
    assign frame_done_o = frame_done_q;
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_dual_stream_aligner.sv
// Bench for dual_stream_aligner: a lockstep vector table, hand-written corner sequences and a
// random run, all checked against a queue-based model of the two streams.
module tb_dual_stream_aligner;

    localparam int W = 4;
    localparam int H = 2;
    localparam int D = 16;

    logic        clk;
    logic        rst_i;
    logic [15:0] a_data, t_data;
    logic        a_valid, t_valid;
    logic        a_ready_o, t_ready_o;
    logic [15:0] i_a_o, i_t_o, col_o, row_o;
    logic        valid_o, frame_done_o, overflow_o;

    dual_stream_aligner #(
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H),
        .FIFO_DEPTH  (D),
        .EXP_WIDTH   (5),
        .FRAC_WIDTH  (10)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .a_data_i    (a_data),
        .a_valid_i   (a_valid),
        .a_ready_o   (a_ready_o),
        .t_data_i    (t_data),
        .t_valid_i   (t_valid),
        .t_ready_o   (t_ready_o),
        .i_a_o       (i_a_o),
        .i_t_o       (i_t_o),
        .col_o       (col_o),
        .row_o       (row_o),
        .valid_o     (valid_o),
        .frame_done_o(frame_done_o),
        .overflow_o  (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model state: accepted-but-unpaired beats per stream, pixel index and held output values.
    logic [15:0] qa[$];
    logic [15:0] qt[$];
    int          pix;
    logic [15:0] m_a, m_t;
    int          m_col, m_row;
    bit          m_ov;
    int          fd_cnt;

    typedef struct {
        logic        av;
        logic [15:0] ad;
        logic        tv;
        logic [15:0] td;
        logic        ev;
        logic [15:0] ea;
        logic [15:0] et;
        logic [15:0] ec;
        logic [15:0] er;
        logic        efd;
    } vec_t;

    vec_t        vecs[10];
    logic [15:0] ftz_in[4];
    logic [15:0] ftz_exp[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_out(input logic [15:0] x);
        logic [15:0] r;
        int          e;
        r = x;
        e = (int'(x) / 1024) % 32;
`ifdef DFDD_ALIGNER_FTZ_EN
        if (e == 0 || e == 31) r = 16'h0000;
`endif
        return r;
    endfunction

    task automatic model_reset();
        qa.delete();
        qt.delete();
        pix    = 0;
        m_a    = '0;
        m_t    = '0;
        m_col  = 0;
        m_row  = 0;
        m_ov   = 1'b0;
    endtask

    // One clock of the model against the DUT, using the currently driven inputs.
    task automatic step();
        bit ra, rt, pop, efd;
        ra  = (qa.size() < D);
        rt  = (qt.size() < D);
        chk("a_ready", 32'(a_ready_o), 32'(ra));
        chk("t_ready", 32'(t_ready_o), 32'(rt));
        pop = (qa.size() > 0) && (qt.size() > 0);
        efd = 1'b0;
        if (pop) begin
            m_a   = model_out(qa.pop_front());
            m_t   = model_out(qt.pop_front());
            m_col = pix % W;
            m_row = (pix / W) % H;
            efd   = ((pix % (W * H)) == (W * H - 1));
            pix++;
        end
        if (a_valid) begin
            if (ra) qa.push_back(a_data);
            else    m_ov = 1'b1;
        end
        if (t_valid) begin
            if (rt) qt.push_back(t_data);
            else    m_ov = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("valid", 32'(valid_o), 32'(pop));
        chk("frame_done", 32'(frame_done_o), 32'(efd));
        chk("overflow", 32'(overflow_o), 32'(m_ov));
        chk("i_a", 32'(i_a_o), 32'(m_a));
        chk("i_t", 32'(i_t_o), 32'(m_t));
        chk("col", 32'(col_o), 32'(m_col));
        chk("row", 32'(row_o), 32'(m_row));
        if (frame_done_o) fd_cnt++;
    endtask

    task automatic idle_inputs();
        a_valid = 1'b0;
        t_valid = 1'b0;
        a_data  = '0;
        t_data  = '0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        rst_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_fd", 32'(frame_done_o), 32'd0);
        chk("rst_ovf", 32'(overflow_o), 32'd0);
        chk("rst_data", 32'({i_a_o, i_t_o}), 32'd0);
        chk("rst_coord", 32'({col_o, row_o}), 32'd0);
        rst_i = 1'b1;
        model_reset();
        #1;
        chk("rst_ready", 32'({a_ready_o, t_ready_o}), 32'd3);
    endtask

    initial begin
        rst_i = 1'b0;
        idle_inputs();
        fd_cnt = 0;
        model_reset();

        // Lockstep table: expected outputs are those visible just after the same cycle's edge.
        vecs[0] = '{1'b1, 16'h3c00, 1'b1, 16'h4000, 1'b0, 16'h0000, 16'h0000, 16'd0, 16'd0, 1'b0};
        vecs[1] = '{1'b1, 16'h3c01, 1'b1, 16'h4001, 1'b1, 16'h3c00, 16'h4000, 16'd0, 16'd0, 1'b0};
        vecs[2] = '{1'b1, 16'h3c02, 1'b1, 16'h4002, 1'b1, 16'h3c01, 16'h4001, 16'd1, 16'd0, 1'b0};
        vecs[3] = '{1'b1, 16'h3c03, 1'b1, 16'h4003, 1'b1, 16'h3c02, 16'h4002, 16'd2, 16'd0, 1'b0};
        vecs[4] = '{1'b1, 16'h3c04, 1'b1, 16'h4004, 1'b1, 16'h3c03, 16'h4003, 16'd3, 16'd0, 1'b0};
        vecs[5] = '{1'b1, 16'h3c05, 1'b1, 16'h4005, 1'b1, 16'h3c04, 16'h4004, 16'd0, 16'd1, 1'b0};
        vecs[6] = '{1'b1, 16'h3c06, 1'b1, 16'h4006, 1'b1, 16'h3c05, 16'h4005, 16'd1, 16'd1, 1'b0};
        vecs[7] = '{1'b1, 16'h3c07, 1'b1, 16'h4007, 1'b1, 16'h3c06, 16'h4006, 16'd2, 16'd1, 1'b0};
        vecs[8] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h3c07, 16'h4007, 16'd3, 16'd1, 1'b1};
        vecs[9] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h3c07, 16'h4007, 16'd3, 16'd1, 1'b0};

        ftz_in[0] = 16'h0001;
        ftz_in[1] = 16'h7c00;
        ftz_in[2] = 16'h7e00;
        ftz_in[3] = 16'h8000;
        for (int i = 0; i < 4; i++) begin
`ifdef DFDD_ALIGNER_FTZ_EN
            ftz_exp[i] = 16'h0000;
`else
            ftz_exp[i] = ftz_in[i];
`endif
        end

        reset_dut();
        for (int i = 0; i < 10; i++) begin
            a_valid = vecs[i].av;
            a_data  = vecs[i].ad;
            t_valid = vecs[i].tv;
            t_data  = vecs[i].td;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_valid", i), 32'(valid_o), 32'(vecs[i].ev));
            chk($sformatf("vec%0d_a", i), 32'(i_a_o), 32'(vecs[i].ea));
            chk($sformatf("vec%0d_t", i), 32'(i_t_o), 32'(vecs[i].et));
            chk($sformatf("vec%0d_col", i), 32'(col_o), 32'(vecs[i].ec));
            chk($sformatf("vec%0d_row", i), 32'(row_o), 32'(vecs[i].er));
            chk($sformatf("vec%0d_fd", i), 32'(frame_done_o), 32'(vecs[i].efd));
        end

        // Skew: I_A fills its FIFO alone, then I_T catches up.
        reset_dut();
        for (int k = 0; k < D; k++) begin
            a_valid = 1'b1;
            a_data  = 16'($urandom);
            step();
        end
        idle_inputs();
        step();
        chk("skew_a_full", 32'(a_ready_o), 32'd0);
        for (int k = 0; k < D; k++) begin
            t_valid = 1'b1;
            t_data  = 16'($urandom);
            step();
        end
        idle_inputs();
        repeat (4) step();

        // Overflow: keep pushing into a full I_A FIFO; extra beats must be dropped.
        reset_dut();
        for (int k = 0; k < D; k++) begin
            a_valid = 1'b1;
            a_data  = 16'h2000 + 16'(k);
            step();
        end
        for (int k = 0; k < 3; k++) begin
            a_valid = 1'b1;
            a_data  = 16'hdead;
            step();
        end
        chk("ovf_set", 32'(overflow_o), 32'd1);
        idle_inputs();
        for (int k = 0; k < D; k++) begin
            t_valid = 1'b1;
            t_data  = 16'h3000 + 16'(k);
            step();
        end
        idle_inputs();
        repeat (4) step();
        chk("ovf_sticky", 32'(overflow_o), 32'd1);

        // Reset mid-frame after three pairs.
        reset_dut();
        for (int g = 0; g < 50 && pix < 3; g++) begin
            a_valid = 1'b1;
            t_valid = 1'b1;
            a_data  = 16'h1200 + 16'(g);
            t_data  = 16'h1300 + 16'(g);
            step();
        end
        chk("mid_pairs", 32'(pix), 32'd3);
        rst_i = 1'b0;
        idle_inputs();
        #1;
        chk("mid_async_valid", 32'(valid_o), 32'd0);
        chk("mid_async_coord", 32'({col_o, row_o}), 32'd0);
        reset_dut();
        for (int k = 0; k < 4; k++) begin
            a_valid = 1'b1;
            t_valid = 1'b1;
            a_data  = 16'h1100 + 16'(k);
            t_data  = 16'h1180 + 16'(k);
            step();
        end
        idle_inputs();
        repeat (3) step();

        // FTZ corner values on both streams.
        reset_dut();
        for (int k = 0; k < 6; k++) begin
            if (k < 4) begin
                a_valid = 1'b1;
                t_valid = 1'b1;
                a_data  = ftz_in[k];
                t_data  = ftz_in[3 - k];
            end else begin
                idle_inputs();
            end
            step();
            if (k >= 1 && k <= 4) begin
                chk($sformatf("ftz_a%0d", k - 1), 32'(i_a_o), 32'(ftz_exp[k - 1]));
                chk($sformatf("ftz_t%0d", k - 1), 32'(i_t_o), 32'(ftz_exp[4 - k]));
            end
        end

        // Two full frames back to back.
        reset_dut();
        fd_cnt = 0;
        for (int k = 0; k < 2 * W * H; k++) begin
            a_valid = 1'b1;
            t_valid = 1'b1;
            a_data  = 16'h4400 + 16'(k);
            t_data  = 16'h4800 + 16'(k);
            step();
        end
        idle_inputs();
        repeat (3) step();
        chk("wrap_fd_count", 32'(fd_cnt), 32'd2);
        chk("wrap_row_end", 32'(row_o), 32'd1);

        // Random traffic with independent valids.
        reset_dut();
        for (int k = 0; k < 400; k++) begin
            a_valid = ($urandom_range(0, 3) != 0);
            t_valid = ($urandom_range(0, 3) != 0);
            a_data  = 16'($urandom);
            t_data  = 16'($urandom);
            step();
        end
        idle_inputs();
        repeat (2 * D + 4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dual_stream_aligner.md
Name: dual_stream_aligner

Overview:
- Input front-end for the DFDD zero scale. Directly upstream of it; its outputs feed the zero-scale i_a_i, i_t_i, col_i, row_i and valid_i inputs.
- Accepts two independent FP16 pixel streams (I_A, I_T) with valid/ready handshakes and buffers each in its own FIFO.
- Pops both FIFOs in lockstep and emits one aligned pixel pair per cycle.
- Attaches raster col/row coordinates, because the downstream window fetchers rely on them.

Parameters:
- IMAGE_WIDTH, 640, pixels per row; col wraps at IMAGE_WIDTH-1.
- IMAGE_HEIGHT, 480, rows per frame; row wraps at IMAGE_HEIGHT-1.
- FIFO_DEPTH, 16, entries per input FIFO; must be a power of 2 and ≥2.
- EXP_WIDTH, 5, FP exponent bits.
- FRAC_WIDTH, 10, FP fraction bits.
- FP_WIDTH_REG, 1+EXP_WIDTH+FRAC_WIDTH, FP word width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-low.
- a_data_i  in  FP_WIDTH_REG  I_A pixel.
- a_valid_i  in  1  I_A pixel valid.
- a_ready_o  out  1  I_A FIFO can accept.
- t_data_i  in  FP_WIDTH_REG  I_T pixel.
- t_valid_i  in  1  I_T pixel valid.
- t_ready_o  out  1  I_T FIFO can accept.
- i_a_o  out  FP_WIDTH_REG  aligned I_A pixel.
- i_t_o  out  FP_WIDTH_REG  aligned I_T pixel.
- col_o  out  16  column of the emitted pair.
- row_o  out  16  row of the emitted pair.
- valid_o  out  1  pair valid; single-cycle qualifier, no backpressure.
- frame_done_o  out  1  one-cycle pulse with the last pixel of a frame.
- overflow_o  out  1  sticky error flag.

Behaviour:
- Clocking and reset: one clock domain (clk_i); reset asynchronous, active-low (rst_i).
- Reset values: all outputs 0, except a_ready_o/t_ready_o = 1 once rst_i deasserts. FIFOs empty, counters 0, overflow_o cleared.
- Accept:
  - A beat is accepted when x_valid_i && x_ready_o.
  - x_ready_o = !full, derived from the registered occupancy count. It is not combinationally dependent on x_valid_i.
- Pop: when both FIFOs are non-empty in a cycle, both heads pop together. The output registers load on that edge and valid_o = 1 the next cycle; otherwise valid_o = 0.
- Latency: no bypass. A beat accepted on edge N is visible at the FIFO head after N; its pair can appear at valid_o after edge N+1. Minimum latency is 2 cycles.
- Data hold: i_a_o/i_t_o/col_o/row_o hold their last values while valid_o = 0.
- Coordinates:
  - col/row counters advance only on pop.
  - col increments; at IMAGE_WIDTH-1 it wraps to 0 and row increments.
  - At (IMAGE_WIDTH-1, IMAGE_HEIGHT-1) both wrap to 0, and frame_done_o pulses in the same cycle as valid_o for that pixel.
  - col_o/row_o carry the counter values before the increment.
- Occupancy: push and pop on the same FIFO in the same cycle leave the count unchanged.
  - Full: no push (ready low), pop allowed.
  - Empty: no pop.
- Overflow: overflow_o sets if x_valid_i = 1 while x_ready_o = 0 on a stream whose producer cannot stall. This is a diagnostic only; the beat is dropped and the FIFO is unaffected. Cleared only by reset.
- Reset mid-frame: FIFOs flushed, counters return to (0,0), valid_o drops immediately (asynchronous).
- Skew: one stream may run up to FIFO_DEPTH beats ahead of the other; beyond that its ready deasserts.

Optional Feature:
- Macro: DFDD_ALIGNER_FTZ_EN.
- Defined: on the pop path, each FP value is sanitised before the output register:
  - subnormals (exp = 0, frac ≠ 0) become +0;
  - NaN/Inf (exp all ones) become +0;
  - the sign of a zero is forced to 0.
  - Latency unchanged.
- Undefined: data passes bit-exact.

Decomposition:
- Package dfdd_pkg holds:
  - EXP_WIDTH/FRAC_WIDTH defaults and the FP16 field-extraction constants (EXP_MSB, EXP_LSB, FRAC_MSB);
  - typedef fp16_t;
  - typedef coord_t (16-bit).
- One sub-module, dfdd_sync_fifo:
  - parameters DATA_WIDTH and DEPTH;
  - ports push, pop, full, empty, count;
  - instantiated twice.
- The FTZ sanitiser is a function in dfdd_pkg.

Test Plan:
- Lockstep: IMAGE_WIDTH=4, IMAGE_HEIGHT=2. Both streams drive 8 beats back-to-back (a = 16'h3c00+k, t = 16'h4000+k) -> valid_o high 8 cycles starting 2 cycles after the first accept. col 0,1,2,3,0,1,2,3; row 0,0,0,0,1,1,1,1. frame_done_o on the 8th beat only.
- Skew: a drives 16 beats while t idles -> a_ready_o low after the 16th, no valid_o. Then t drives 16 beats -> 16 pairs, a_ready_o reasserts the cycle after the first pop.
- Overflow: a_valid_i held with a FIFO full -> overflow_o = 1 and stays set; FIFO contents unchanged (pairs match the first 16 a values).
- Reset mid-frame: rst_i low after 3 pairs, then 4 fresh pairs -> coordinates restart at (0,0); no stale data appears.
- FTZ (macro defined): a = 16'h0001, 16'h7c00, 16'h7e00, 16'h8000 -> i_a_o = 16'h0000 for all four. Without the macro, outputs equal the inputs.
- Wrap: 2 full frames of 4x2 -> frame_done_o pulses exactly twice; row returns to 0 after each.
